car_sensor_conditioner: RTL

//  Upstream stage of trafficlight: turns the raw, asynchronous side-road loop-sensor
//  bit into the clean, debounced 'car' request that trafficlight consumes.

---
 rtl/car_sensor_if.sv | 30 +++
 rtl/car_sensor_conditioner.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/car_sensor_if.sv
// Bundles the loop-sensor input, the operator clear and the conditioned request outputs
// exchanged between the sensor conditioner and its neighbours.
interface car_sensor_if #(
  parameter int CNT_W = 8
);
  logic             sensor_raw;
  logic             fault_clr;
  logic             car;
  logic             car_rise;
  logic             fault;
  logic [CNT_W-1:0] car_count;

  modport master (
    output sensor_raw,
    output fault_clr,
    input  car,
    input  car_rise,
    input  fault,
    input  car_count
  );

  modport slave (
    input  sensor_raw,
    input  fault_clr,
    output car,
    output car_rise,
    output fault,
    output car_count
  );
endinterface

// File: rtl/car_sensor_conditioner.sv
// Synchronises and debounces the side-road loop sensor into a clean 'car' request,
// latches a stuck-high fault and counts completed vehicle passages.
module car_sensor_conditioner #(
  parameter int DEB_ON    = 4,
  parameter int DEB_OFF   = 4,
  parameter int STUCK_MAX = 1000,
  parameter int CNT_W     = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  car_sensor_if.slave   bus
);

  localparam int DEB_MAX = (DEB_ON > DEB_OFF) ? DEB_ON : DEB_OFF;
  localparam int DEB_W   = $clog2(DEB_MAX + 1);
  localparam int STK_W   = $clog2(STUCK_MAX + 1);

  localparam logic [DEB_W-1:0] DEB_ON_LAST  = DEB_W'(DEB_ON - 1);
  localparam logic [DEB_W-1:0] DEB_OFF_LAST = DEB_W'(DEB_OFF - 1);
  localparam logic [STK_W-1:0] STK_LAST     = STK_W'(STUCK_MAX - 1);

  typedef enum logic [2:0] {
    IDLE,
    QUAL,
    PRESENT,
    REL,
    FAULT
  } state_t;

  logic             sync1_reg;
  logic             sync2_reg;
  state_t           state_reg,  state_next;
  logic [DEB_W-1:0] deb_reg,    deb_next;
  logic [STK_W-1:0] stk_reg,    stk_next;
  logic [CNT_W-1:0] count_reg,  count_next;
  logic             car_reg,    car_next;
  logic             rise_reg,   rise_next;
  logic             fault_reg,  fault_next;
  logic             s;

  assign s = sync2_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      state_reg <= IDLE;
      deb_reg   <= '0;
      stk_reg   <= '0;
      count_reg <= '0;
      car_reg   <= 1'b0;
      rise_reg  <= 1'b0;
      fault_reg <= 1'b0;
    end else begin
      sync1_reg <= bus.sensor_raw;
      sync2_reg <= sync1_reg;
      state_reg <= state_next;
      deb_reg   <= deb_next;
      stk_reg   <= stk_next;
      count_reg <= count_next;
      car_reg   <= car_next;
      rise_reg  <= rise_next;
      fault_reg <= fault_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    deb_next   = deb_reg;
    stk_next   = stk_reg;
    count_next = count_reg;
    rise_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (s) begin
          if (DEB_ON == 1) begin
            state_next = PRESENT;
            deb_next   = '0;
            stk_next   = '0;
            rise_next  = 1'b1;
          end else begin
            state_next = QUAL;
            deb_next   = DEB_W'(1);
          end
        end
      end

      QUAL: begin
        if (!s) begin
          state_next = IDLE;
          deb_next   = '0;
        end else if (deb_reg == DEB_ON_LAST) begin
          state_next = PRESENT;
          deb_next   = '0;
          stk_next   = '0;
          rise_next  = 1'b1;
        end else begin
          deb_next = deb_reg + DEB_W'(1);
        end
      end

      // A completed release always beats the stuck threshold landing on the same cycle.
      PRESENT: begin
        if (!s && (DEB_OFF == 1)) begin
          state_next = IDLE;
          deb_next   = '0;
          count_next = count_reg + CNT_W'(1);
        end else if (stk_reg == STK_LAST) begin
          state_next = FAULT;
        end else if (!s) begin
          state_next = REL;
          deb_next   = DEB_W'(1);
          stk_next   = stk_reg + STK_W'(1);
        end else begin
          stk_next = stk_reg + STK_W'(1);
        end
      end

      REL: begin
        if (!s && (deb_reg == DEB_OFF_LAST)) begin
          state_next = IDLE;
          deb_next   = '0;
          count_next = count_reg + CNT_W'(1);
        end else if (stk_reg == STK_LAST) begin
          state_next = FAULT;
        end else if (s) begin
          state_next = PRESENT;
          deb_next   = '0;
          stk_next   = stk_reg + STK_W'(1);
        end else begin
          deb_next = deb_reg + DEB_W'(1);
          stk_next = stk_reg + STK_W'(1);
        end
      end

      // Fail-safe: keep requesting service until the sensor reads low and the operator clears.
      FAULT: begin
        if (bus.fault_clr && !s) begin
          state_next = IDLE;
          deb_next   = '0;
          stk_next   = '0;
        end
      end

      default: begin
        state_next = IDLE;
        deb_next   = '0;
        stk_next   = '0;
      end
    endcase

    car_next   = (state_next == PRESENT) || (state_next == REL) || (state_next == FAULT);
    fault_next = (state_next == FAULT);
  end

  assign bus.car       = car_reg;
  assign bus.car_rise  = rise_reg;
  assign bus.fault     = fault_reg;
  assign bus.car_count = count_reg;

endmodule
